// File: rtl/zip_unpack_4to1.sv
// zip_unpack_4to1: expands 32-bit words holding four 8-bit compressed samples
// into four {I16,Q16} samples on an AXI-Stream style output, one per clock.
// Lane order inside a word: [15:8], [23:16], [31:24], [7:0].
// Optional macro ZIP_UNPACK_MIDRISE_EN: I[7:0] filled with 8'h80 (mid-step
// reconstruction) instead of 8'h00.
module zip_unpack_4to1 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [CNT_W-1:0] o_sample_cnt
);

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;

`ifdef ZIP_UNPACK_MIDRISE_EN
   localparam logic [LANE_W-1:0] FILL = 8'h80;
`else
   localparam logic [LANE_W-1:0] FILL = 8'h00;
`endif

   typedef enum logic {EMPTY, DRAIN} state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic [WIDTH-1:0]                 r_hold;
   logic                             r_hold_last;
   logic [1:0]                       r_lane;
   logic [1:0]                       w_lane_nxt;
   logic [CNT_W-1:0]                 r_cnt;
   logic                             w_full;
   logic                             w_last_lane;
   logic                             w_in_hs;
   logic                             w_out_hs;
   logic                             w_load;
   logic [NUM_LANES-1:0][LANE_W-1:0] w_lane_byte;

   // Reorder the held word so lane index k maps straight to output sample k.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_lane_byte[g] = r_hold[LANE_W*((g+1)%NUM_LANES) +: LANE_W];
   end

   assign w_full      = (r_state == DRAIN);
   assign w_last_lane = (r_lane == 2'd3);
   // Ready while empty, or when the last lane leaves this cycle (no bubble).
   // Held low during reset so nothing is accepted while the block is cleared.
   assign i_tready    = ~reset & (~w_full | (o_tready & w_last_lane));
   assign w_in_hs     = i_tvalid & i_tready;
   assign w_out_hs    = w_full & o_tready;
   assign o_sample_cnt = r_cnt;

   // Next-state, lane advance and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      w_load      = 1'b0;
      o_tvalid    = w_full;
      o_tlast     = w_full & r_hold_last & w_last_lane;
      o_tdata     = '0;
      if (w_full) o_tdata = {w_lane_byte[r_lane], FILL, 16'h0000};
      case (r_state)
         EMPTY: begin
            if (w_in_hs) begin
               w_state_nxt = DRAIN;
               w_load      = 1'b1;
               w_lane_nxt  = 2'd0;
            end
         end
         DRAIN: begin
            if (w_out_hs) begin
               if (!w_last_lane) begin
                  w_lane_nxt = r_lane + 2'd1;
               end else if (w_in_hs) begin
                  w_load     = 1'b1;
                  w_lane_nxt = 2'd0;
               end else begin
                  w_state_nxt = EMPTY;
                  w_lane_nxt  = 2'd0;
               end
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // State register; reset drops any partially drained word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Held word, its tlast, lane pointer and the output sample counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold      <= '0;
         r_hold_last <= 1'b0;
         r_lane      <= 2'd0;
         r_cnt       <= '0;
      end else begin
         r_lane <= w_lane_nxt;
         if (w_load) begin
            r_hold      <= i_tdata;
            r_hold_last <= i_tlast;
         end
         if (w_out_hs) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_zip_unpack_4to1.sv
// Bench for zip_unpack_4to1: directed scenarios plus random traffic, checked
// against a queue of expected samples built from each accepted word.
module tb_zip_unpack_4to1;

`ifdef ZIP_UNPACK_MIDRISE_EN
   localparam logic [7:0] FILL = 8'h80;
`else
   localparam logic [7:0] FILL = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] i_tdata = '0;
   logic        i_tlast = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        o_tready = 1'b0;
   logic        i_tready, o_tlast, o_tvalid;
   logic [31:0] o_tdata;
   logic [15:0] o_sample_cnt;
   logic        i_tready4, o_tlast4, o_tvalid4;
   logic [31:0] o_tdata4;
   logic [3:0]  o_sample_cnt4;

   always #5 clk = ~clk;

   zip_unpack_4to1 #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
      .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .o_sample_cnt(o_sample_cnt));

   // Narrow-counter copy on the same stream, used for the wrap check.
   zip_unpack_4to1 #(.WIDTH(32), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready4), .o_tdata(o_tdata4),
      .o_tlast(o_tlast4), .o_tvalid(o_tvalid4), .o_tready(o_tready),
      .o_sample_cnt(o_sample_cnt4));

   typedef struct packed { logic [31:0] d; logic l; } smp_t;

   smp_t        q[$];
   int unsigned mcnt = 0;
   int          tests = 0;
   int          fails = 0;
   int          hs_idx = 0;
   int          last_n = 0;
   int          last_pos = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] expand(input logic [7:0] b);
      return {b, FILL, 16'h0000};
   endfunction

   // One clock: drive, compare at negedge against the model, update model at posedge.
   task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                      input logic rdy, output logic acc);
      logic exp_rdy, out_hs;
      smp_t s;
      i_tvalid = v; i_tdata = d; i_tlast = l; o_tready = rdy;
      @(negedge clk);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && rdy);
      chk("o_tvalid", {31'd0, o_tvalid}, {31'd0, q.size() > 0});
      chk("i_tready", {31'd0, i_tready}, {31'd0, exp_rdy});
      if (q.size() > 0) begin
         chk("o_tdata", o_tdata, q[0].d);
         chk("o_tlast", {31'd0, o_tlast}, {31'd0, q[0].l});
      end else begin
         chk("o_tlast_idle", {31'd0, o_tlast}, 32'd0);
      end
      chk("cnt16", {16'd0, o_sample_cnt}, mcnt & 32'hFFFF);
      chk("cnt4", {28'd0, o_sample_cnt4}, mcnt & 32'hF);
      out_hs = (q.size() > 0) && rdy;
      acc = v && exp_rdy;
      if (o_tvalid && rdy) begin
         hs_idx++;
         if (o_tlast) begin last_n++; last_pos = hs_idx; end
      end
      @(posedge clk);
      if (out_hs) begin void'(q.pop_front()); mcnt++; end
      if (acc) begin
         s.d = expand(d[15:8]);  s.l = 1'b0; q.push_back(s);
         s.d = expand(d[23:16]); s.l = 1'b0; q.push_back(s);
         s.d = expand(d[31:24]); s.l = 1'b0; q.push_back(s);
         s.d = expand(d[7:0]);   s.l = l;    q.push_back(s);
      end
      #1;
   endtask

   initial begin
      logic        acc, pend, pl;
      logic [31:0] pd;
      logic [31:0] seq [4];
      logic [31:0] w [3];
      int          n, base;

      // Reset state
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_i_tready", {31'd0, i_tready}, 32'd0);
      chk("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
      chk("rst_o_tdata", o_tdata, 32'd0);
      chk("rst_o_tlast", {31'd0, o_tlast}, 32'd0);
      chk("rst_cnt", {16'd0, o_sample_cnt}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Single word, fixed lane order
      seq[0] = expand(8'hBB); seq[1] = expand(8'hCC);
      seq[2] = expand(8'hDD); seq[3] = expand(8'hAA);
      cyc(1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, acc);
      chk("single_acc", {31'd0, acc}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("single_seq", o_tdata, seq[i]);
         chk("single_last", {31'd0, o_tlast}, {31'd0, i == 3});
         cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
      end
      chk("single_cnt", {16'd0, o_sample_cnt}, 32'd4);

      // Back-to-back: 3 words, 12 samples in 13 cycles means no bubbles
      for (int i = 0; i < 3; i++) w[i] = $urandom;
      n = 0; base = int'(mcnt);
      for (int c = 0; c < 13; c++) begin
         cyc(n < 3, w[n % 3], 1'b0, 1'b1, acc);
         if (acc) n++;
      end
      chk("b2b_words", n, 32'd3);
      chk("b2b_cnt", {16'd0, o_sample_cnt}, (base + 12) & 32'hFFFF);

      // Backpressure on lane 1 with a new word offered
      pd = $urandom;
      cyc(1'b1, pd, 1'b0, 1'b1, acc);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
      pd = $urandom;
      for (int c = 0; c < 5; c++) begin
         cyc(1'b1, pd, 1'b1, 1'b0, acc);
         chk("bp_no_accept", {31'd0, acc}, 32'd0);
      end
      n = 0;
      do begin cyc(1'b1, pd, 1'b1, 1'b1, acc); n++; end while (!acc && n < 20);
      chk("bp_resume_acc", {31'd0, acc}, 32'd1);
      for (int c = 0; c < 4; c++) cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);

      // tlast mapping over two words
      hs_idx = 0; last_n = 0; last_pos = -1; n = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(n < 2, $urandom, n == 1, 1'b1, acc);
         if (acc) n++;
      end
      chk("tlast_count", last_n, 32'd1);
      chk("tlast_pos", last_pos, 32'd8);

      // Mid-word reset at lane 2
      cyc(1'b1, $urandom, 1'b1, 1'b1, acc);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
      #2 reset = 1'b1;
      #1;
      chk("mrst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
      chk("mrst_cnt", {16'd0, o_sample_cnt}, 32'd0);
      chk("mrst_i_tready", {31'd0, i_tready}, 32'd0);
      q.delete(); mcnt = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1 chk("mrst_release_rdy", {31'd0, i_tready}, 32'd1);

      // Five streamed words: narrow counter wraps 20 -> 4
      n = 0;
      for (int c = 0; c < 21; c++) begin
         cyc(n < 5, $urandom, 1'b0, 1'b1, acc);
         if (acc) n++;
      end
      chk("wrap_cnt4", {28'd0, o_sample_cnt4}, 32'd4);
      chk("wrap_cnt16", {16'd0, o_sample_cnt}, 32'd20);

      // Random traffic with AXI-compliant upstream hold
      pend = 1'b0; pd = '0; pl = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!pend && ($urandom_range(3) != 0)) begin
            pend = 1'b1; pd = $urandom; pl = $urandom_range(1) == 1;
         end
         cyc(pend, pd, pl, $urandom_range(2) != 0, acc);
         if (acc) pend = 1'b0;
      end
      n = 0;
      while (q.size() > 0 && n < 20) begin cyc(1'b0, 32'd0, 1'b0, 1'b1, acc); n++; end
      chk("final_drain", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/zip_unpack_4to1.md
Name: zip_unpack_4to1

Overview:
- Downstream companion of the 4:1 sample packer. It consumes 32-bit words, each carrying four 8-bit compressed samples, and re-expands them into four 32-bit {I16,Q16} samples on an AXI-Stream-style output.
- Sits on the receive/loopback side of the QPSK RFNoC chain, between the packed-transport stage and sample-domain consumers such as the demodulator and FIFOs.
- Output sample rate is four times the input word rate.

Parameters:
- WIDTH, 32, data width of input word and output sample; only 32 is supported.
- CNT_W, 16, width of the free-running sample counter output.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- i_tdata  in  32  packed word, four 8-bit lanes
- i_tlast  in  1  packet end marker on the packed word
- i_tvalid  in  1  input word valid
- i_tready  out  1  input word accepted when i_tvalid & i_tready
- o_tdata  out  32  expanded sample, I in [31:16], Q in [15:0]
- o_tlast  out  1  packet end on the expanded stream
- o_tvalid  out  1  output sample valid
- o_tready  in  1  downstream ready
- o_sample_cnt  out  CNT_W  count of output samples transferred (o_tvalid & o_tready), wraps

Behaviour:
- Lane order within a word is fixed:
  - sample 0 = [15:8]
  - sample 1 = [23:16]
  - sample 2 = [31:24]
  - sample 3 = [7:0]
- Each lane byte is the upper 8 bits of the I component.
- Expansion: o_tdata = {lane_byte, FILL, 16'h0000}, where FILL = 8'h00 (see Optional Feature). Q is always zero.
- State:
  - hold_reg [31:0] holds the current word.
  - hold_last is the i_tlast captured with that word.
  - full flag.
  - lane counter lane [1:0].
- States:
  - EMPTY (full=0): o_tvalid=0, i_tready=1.
  - DRAIN (full=1): o_tvalid=1; o_tdata selects hold_reg lane `lane`.
- Transitions:
  - EMPTY + input handshake: capture word and i_tlast, set full, lane=0 → DRAIN.
  - DRAIN + output handshake with lane<3: lane increments.
  - DRAIN + output handshake with lane==3 and no input handshake: full cleared → EMPTY.
  - DRAIN + output handshake with lane==3 and input handshake in the same cycle: new word loaded, lane=0, stay in DRAIN. No bubble, so sustained throughput is 1 sample per clock.
- i_tready = ~full | (o_tready & lane==3). It is combinational and must not depend on i_tvalid.
- o_tlast = full & hold_last & (lane==3). It is never asserted on lanes 0–2.
- o_tvalid = full. Once asserted it is held, with o_tdata stable, until accepted (AXI rule). o_tready low stalls lane advance.
- Latency: a word accepted at edge N presents lane 0 at o_tdata after edge N; first sample valid in cycle N+1.
- o_sample_cnt increments by 1 per output handshake and wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous, any time including mid-word):
  - full=0, lane=0, hold_reg=0, hold_last=0, o_sample_cnt=0.
  - Outputs read o_tvalid=0, o_tlast=0, o_tdata=0.
  - i_tready is forced 0 while reset is asserted and returns to 1 in the first cycle after release.
  - A partially drained word is discarded; no sample of it is emitted after reset.
- i_tvalid while full and not on lane 3 with o_tready: ignored (not accepted). Upstream must hold data.
- i_tlast on every word is legal: each word then yields a 4-sample packet with o_tlast on the 4th.

Optional Feature:
- Macro ZIP_UNPACK_MIDRISE_EN.
- Defined: FILL = 8'h80. Mid-step reconstruction, so o_tdata[23:16]=8'h80 on every sample.
- Undefined: FILL = 8'h00.
- No other behaviour changes.

Test Plan:
- Single word: after reset, send i_tdata=32'hDDCCBBAA with i_tlast=1 and o_tready=1. Required response:
  - o_tdata sequence 32'hBB000000, 32'hCC000000, 32'hDD000000, 32'hAA000000 on consecutive cycles.
  - o_tlast only on 32'hAA000000.
  - o_sample_cnt=4.
  - With ZIP_UNPACK_MIDRISE_EN the same sequence reads 32'hBB800000, 32'hCC800000, 32'hDD800000, 32'hAA800000.
- Back-to-back: 3 words streamed with i_tvalid=1 and o_tready=1. Required response:
  - 12 samples with o_tvalid continuously high.
  - i_tready high only on cycles where lane==3 (plus the first word).
  - No bubble cycles.
- Backpressure: drop o_tready for 5 cycles while lane==1. Required response:
  - o_tdata holds lane-1 value and o_tvalid stays 1.
  - i_tready stays 0.
  - Draining resumes at lane 1, and no sample is lost or duplicated.
- tlast mapping: words W0 (tlast=0) and W1 (tlast=1). Required response: o_tlast asserted exactly once, on the 8th sample.
- Mid-word reset: assert reset asynchronously while lane==2, for 2 cycles. Required response:
  - o_tvalid=0 immediately and o_sample_cnt=0.
  - After release, i_tready=1, and a new word yields lane 0 first with no stale samples.
- Counter wrap with CNT_W=4: stream 5 words (20 samples). Required response: o_sample_cnt reads 4.
